// File: rtl/tl_rx_cpl_tag_tracker_if.sv
// Bundle of request-issue, completion-receive and error-report signals for the
// completion tag tracker; the tracker connects through the slave modport.
interface tl_rx_cpl_tag_tracker_if #(
  parameter int REQUESTER_ID_WIDTH = 16,
  parameter int TAG_WIDTH          = 10,
  parameter int NUM_TAGS           = 32
);
  logic [REQUESTER_ID_WIDTH-1:0]    cfg_req_id;
  logic                             uc_en;
  logic                             tx_np_valid;
  logic [TAG_WIDTH-1:0]             tx_np_tag;
  logic                             rx_cpl_valid;
  logic [2:0]                       rx_typ;
  logic [REQUESTER_ID_WIDTH-1:0]    rx_req_id;
  logic [TAG_WIDTH-1:0]             rx_req_tag;
  logic                             rx_cpl_last;
  logic                             uc_error;
  logic [TAG_WIDTH-1:0]             uc_error_tag;
  logic                             tx_alloc_err;
  logic [$clog2(NUM_TAGS+1)-1:0]    outstanding_cnt;
  logic                             cto_error;
  logic [TAG_WIDTH-1:0]             cto_tag;

  modport master (
    output cfg_req_id, uc_en, tx_np_valid, tx_np_tag, rx_cpl_valid, rx_typ,
           rx_req_id, rx_req_tag, rx_cpl_last,
    input  uc_error, uc_error_tag, tx_alloc_err, outstanding_cnt, cto_error, cto_tag
  );

  modport slave (
    input  cfg_req_id, uc_en, tx_np_valid, tx_np_tag, rx_cpl_valid, rx_typ,
           rx_req_id, rx_req_tag, rx_cpl_last,
    output uc_error, uc_error_tag, tx_alloc_err, outstanding_cnt, cto_error, cto_tag
  );
endinterface

// File: rtl/tl_rx_cpl_tag_tracker.sv
// Non-posted tag busy tracking with unexpected-completion detection.
// Optional completion timeout per tag when TL_RX_CPL_TIMEOUT_EN is defined.
module tl_rx_cpl_tag_tracker #(
  parameter int REQUESTER_ID_WIDTH = 16,
  parameter int TAG_WIDTH          = 10,
  parameter int NUM_TAGS           = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input logic                    clk,
  input logic                    rst,
  tl_rx_cpl_tag_tracker_if.slave bus
);
  localparam int         CNT_W   = $clog2(NUM_TAGS + 1);
  localparam logic [2:0] TYP_CPL = 3'b010;

  logic [NUM_TAGS-1:0]  busy_q, busy_d;
  logic                 uc_error_q, uc_error_d;
  logic [TAG_WIDTH-1:0] uc_error_tag_q, uc_error_tag_d;
  logic                 tx_alloc_err_q, tx_alloc_err_d;
  logic [NUM_TAGS-1:0]  alloc_oh, cpl_oh, alloc_set, cpl_clr, expired, to_oh;
  logic                 alloc_ok, cpl_qual, cpl_exp;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TAGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_TAGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [TAG_WIDTH-1:0] encode(input logic [NUM_TAGS-1:0] oh);
    logic [TAG_WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_TAGS; i++) if (oh[i]) t = TAG_WIDTH'(i);
    return t;
  endfunction

  // Out-of-range tags decode to an all-zero one-hot, so range checks fall out of the OR.
  always_comb begin
    alloc_oh = '0;
    cpl_oh   = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      alloc_oh[i] = (bus.tx_np_tag == TAG_WIDTH'(i));
      cpl_oh[i]   = (bus.rx_req_tag == TAG_WIDTH'(i));
    end
  end

  always_comb begin
    alloc_ok       = bus.tx_np_valid && (|(alloc_oh & ~busy_q));
    alloc_set      = alloc_ok ? alloc_oh : '0;
    tx_alloc_err_d = bus.tx_np_valid && !alloc_ok;
    cpl_qual       = bus.rx_cpl_valid && (bus.rx_typ == TYP_CPL);
    cpl_exp        = cpl_qual && (bus.rx_req_id == bus.cfg_req_id) &&
                     (|(cpl_oh & busy_q & ~expired));
    cpl_clr        = (cpl_exp && bus.rx_cpl_last) ? cpl_oh : '0;
    uc_error_d     = cpl_qual && !cpl_exp && bus.uc_en;
    uc_error_tag_d = uc_error_d ? bus.rx_req_tag : uc_error_tag_q;
    // Isolate the lowest expired tag for release this cycle.
    to_oh          = expired & (~expired + NUM_TAGS'(1));
    busy_d         = (busy_q | alloc_set) & ~cpl_clr & ~to_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q         <= '0;
      uc_error_q     <= 1'b0;
      uc_error_tag_q <= '0;
      tx_alloc_err_q <= 1'b0;
    end else begin
      busy_q         <= busy_d;
      uc_error_q     <= uc_error_d;
      uc_error_tag_q <= uc_error_tag_d;
      tx_alloc_err_q <= tx_alloc_err_d;
    end
  end

  assign bus.uc_error        = uc_error_q;
  assign bus.uc_error_tag    = uc_error_tag_q;
  assign bus.tx_alloc_err    = tx_alloc_err_q;
  assign bus.outstanding_cnt = popcount(busy_q);

`ifdef TL_RX_CPL_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0]     age_q [NUM_TAGS];
  logic [AGE_W-1:0]     age_d [NUM_TAGS];
  logic                 cto_error_q, cto_error_d;
  logic [TAG_WIDTH-1:0] cto_tag_q, cto_tag_d;

  // Age saturates at TIMEOUT_CYCLES; released tags keep a stale age until reallocated.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      age_d[i]   = age_q[i];
      expired[i] = busy_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYCLES));
      if (alloc_set[i])
        age_d[i] = '0;
      else if (busy_q[i] && (age_q[i] != AGE_W'(TIMEOUT_CYCLES)))
        age_d[i] = age_q[i] + AGE_W'(1);
    end
    cto_error_d = |expired;
    cto_tag_d   = cto_error_d ? encode(to_oh) : cto_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= '0;
      cto_error_q <= 1'b0;
      cto_tag_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= age_d[i];
      cto_error_q <= cto_error_d;
      cto_tag_q   <= cto_tag_d;
    end
  end

  assign bus.cto_error = cto_error_q;
  assign bus.cto_tag   = cto_tag_q;
`else
  logic unused_timeout_cfg;

  assign expired            = '0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.cto_error      = 1'b0;
  assign bus.cto_tag        = '0;
`endif
endmodule

// File: doc/tl_rx_cpl_tag_tracker.md
TL_RX_CPL_TAG_TRACKER -- requirements
Module: tl_rx_cpl_tag_tracker

Interface
REQ-001 SHALL provide parameters: REQUESTER_ID_WIDTH, default 16, requester ID width; TAG_WIDTH, default 10, tag width; NUM_TAGS, default 32, tracked tags 0..NUM_TAGS-1 (2..2^TAG_WIDTH); TIMEOUT_CYCLES, default 1024, completion timeout in clocks (>=2).
REQ-002 SHALL provide ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_req_id  in  REQUESTER_ID_WIDTH  own requester ID
- uc_en  in  1  unexpected-completion reporting enable
- tx_np_valid  in  1  non-posted request issued this cycle
- tx_np_tag  in  TAG_WIDTH  tag of the issued request
- rx_cpl_valid  in  1  received-TLP header valid
- rx_typ  in  3  TLP type; COMPLETION = 3'b010
- rx_req_id  in  REQUESTER_ID_WIDTH  requester ID field of the completion
- rx_req_tag  in  TAG_WIDTH  tag field of the completion
- rx_cpl_last  in  1  final completion of the request
- uc_error  out  1  one-cycle pulse, unexpected completion
- uc_error_tag  out  TAG_WIDTH  rx_req_tag of the offending completion
- tx_alloc_err  out  1  one-cycle pulse, illegal tag allocation
- outstanding_cnt  out  $clog2(NUM_TAGS+1)  number of busy tags
- cto_error  out  1  one-cycle pulse, completion timeout
- cto_tag  out  TAG_WIDTH  tag that timed out

Function
REQ-003 SHALL keep a NUM_TAGS-bit busy bitmap; all checks use the registered bitmap value from the start of the cycle.
REQ-004 Allocation: tx_np_valid with tx_np_tag < NUM_TAGS and tag not busy SHALL set the bit, visible next cycle.
REQ-005 Allocation of a busy tag or a tag >= NUM_TAGS SHALL leave state unchanged and pulse tx_alloc_err the next cycle.
REQ-006 Completion qualifies when rx_cpl_valid=1 and rx_typ=COMPLETION; non-completions SHALL be ignored.
REQ-007 Qualified completion SHALL be expected iff rx_req_id==cfg_req_id, rx_req_tag<NUM_TAGS and the tag is busy and not expired.
REQ-008 Expected completion with rx_cpl_last=1 SHALL clear the bit; with rx_cpl_last=0 the bit SHALL stay set.
REQ-009 Unexpected completion with uc_en=1 SHALL pulse uc_error for exactly one cycle, the cycle after, with uc_error_tag=rx_req_tag; with uc_en=0 no pulse. Unexpected completions SHALL never change state.
REQ-010 uc_error_tag SHALL hold its last value when uc_error=0; cto_tag likewise.
REQ-011 Same-cycle release of tag T and allocation of T: the allocation SHALL be rejected per REQ-005; T ends up free.
REQ-012 Same-cycle allocation of T and completion for T: the completion SHALL see T not busy and is unexpected; T becomes busy.
REQ-013 outstanding_cnt SHALL equal the bitmap popcount every cycle; it can change by +1, -1, -2 or 0 per cycle (one allocation, one completion release, one timeout release).

Reset
REQ-014 rst=1 at a clock edge SHALL clear the bitmap and all timers, and zero uc_error, uc_error_tag, tx_alloc_err, outstanding_cnt, cto_error and cto_tag.
REQ-015 Inputs during a reset cycle SHALL be ignored; outstanding requests at reset SHALL be discarded without cto_error.

Configuration
REQ-016 Macro TL_RX_CPL_TIMEOUT_EN defined: each tag has a saturating age counter. It is zeroed by allocation and increments every cycle while the tag is busy. A tag is expired when its counter equals TIMEOUT_CYCLES.
REQ-017 Each cycle, the lowest-index expired tag SHALL be released, with cto_error pulsed and cto_tag set the next cycle. A single timeout SHALL therefore appear in cycle N+TIMEOUT_CYCLES+2 for allocation cycle N. Further expired tags are reported one per cycle, in ascending order.
REQ-018 Macro TL_RX_CPL_TIMEOUT_EN not defined: no age counters exist; cto_error and cto_tag are tied to 0. Ports are unchanged.

Verification
REQ-019 Directed scenarios (NUM_TAGS=32, cfg_req_id=16'h0100, uc_en=1):
- Allocate tag 5, then completion with tag 5, ID 16'h0100, last=1 -> no uc_error; outstanding_cnt goes 1 then 0.
- Completion with tag 5, ID 16'h0200 while tag 5 is busy -> uc_error=1 for one cycle, uc_error_tag=5, tag 5 still busy.
- Completion with tag 40 -> uc_error with uc_error_tag=40; the same stimulus with uc_en=0 -> no pulse.
- Allocate tag 7 twice -> tx_alloc_err on the second; outstanding_cnt=1. Same-cycle last completion of 7 and allocation of 7 -> tx_alloc_err, cnt=0.
- TIMEOUT_CYCLES=16, macro on: allocate tags 3 and 9 in cycle 10 -> cto_error with cto_tag=3 in cycle 28, cto_tag=9 in cycle 29; a later completion for 3 -> uc_error.
- rst pulsed with 4 tags busy -> all outputs 0 next cycle; no cto_error follows.
